// File: rtl/ode_ram_pkg.sv
// ode_ram_pkg: shared defaults and types for the ODE solver RAM arbiter.
//   DEF_NREQ/DEF_NBANK/DEF_AW/DEF_DW : default requester/bank counts and widths
//   REQ_IO/REQ_EULER/REQ_STEP        : requester IDs (IO loader, Euler datapath,
//                                      step-size control)
//   lock_state_e                     : per-bank lock state (used when
//                                      RAM_ARB_LOCK_EN is defined)
package ode_ram_pkg;

    localparam int DEF_NREQ  = 3;
    localparam int DEF_NBANK = 4;
    localparam int DEF_AW    = 12;
    localparam int DEF_DW    = 64;

    localparam int REQ_IO    = 0;
    localparam int REQ_EULER = 1;
    localparam int REQ_STEP  = 2;

    // Width of the idle-cycle counter that breaks a stale bank lock.
    localparam int LOCK_TMO_W = 4;

    typedef enum logic {
        LK_IDLE   = 1'b0,
        LK_LOCKED = 1'b1
    } lock_state_e;

    // Width of a requester index; at least one bit so NREQ=1 still elaborates.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one bank's round-robin arbiter with optional bank-lock FSM.
// Optional feature macro: RAM_ARB_LOCK_EN (bank lock with 16-cycle idle timeout).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   req       : per-requester request already filtered to this bank
//   lock      : per-requester lock request (ignored without RAM_ARB_LOCK_EN)
//   gnt       : one-hot combinational grant
//   gnt_any   : some requester is granted this cycle
//   gnt_id    : index of the granted requester (valid with gnt_any)
module rr_arbiter
    import ode_ram_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = id_w(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] lock,
    output logic [NREQ-1:0] gnt,
    output logic            gnt_any,
    output logic [IW-1:0]   gnt_id
);

    logic [IW-1:0]   last_winner;
    logic [NREQ-1:0] elig;

`ifdef RAM_ARB_LOCK_EN
    lock_state_e           state;
    logic [IW-1:0]         owner;
    logic [LOCK_TMO_W-1:0] tmo;

    // A locked bank is visible only to its owner.
    always_comb begin
        elig = req;
        if (state == LK_LOCKED) begin
            elig        = '0;
            elig[owner] = req[owner];
        end
    end

    // tmo counts consecutive cycles without an owner request; when it has
    // seen 16 of them the lock is dropped so a vanished owner cannot starve
    // the other requesters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LK_IDLE;
            owner <= '0;
            tmo   <= '0;
        end else begin
            case (state)
                LK_IDLE: begin
                    if (gnt_any && lock[gnt_id]) begin
                        state <= LK_LOCKED;
                        owner <= gnt_id;
                        tmo   <= '0;
                    end
                end
                LK_LOCKED: begin
                    // An owner request is always granted while locked.
                    if (req[owner]) begin
                        tmo <= '0;
                        if (!lock[owner]) state <= LK_IDLE;
                    end else if (tmo == {LOCK_TMO_W{1'b1}}) begin
                        state <= LK_IDLE;
                        tmo   <= '0;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                default: state <= LK_IDLE;
            endcase
        end
    end
`else
    wire unused_lock = ^lock;
    assign elig = req;
`endif

    // Search starts just after the previous winner and wraps.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_id  = last_winner;
        for (int i = 1; i <= NREQ; i++) begin
            if (!gnt_any && elig[(int'(last_winner) + i) % NREQ]) begin
                gnt_any = 1'b1;
                gnt_id  = IW'((int'(last_winner) + i) % NREQ);
            end
        end
        if (gnt_any) gnt[gnt_id] = 1'b1;
    end

    // Reset to NREQ-1 so requester 0 is first in line.
    always_ff @(posedge clk) begin
        if (rst)          last_winner <= IW'(NREQ - 1);
        else if (gnt_any) last_winner <= gnt_id;
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: multi-bank RAM arbiter for the ODE solver requesters.
// Each bank has its own rr_arbiter; a grant in cycle t drives the bank's
// registered RAM port in t+1 and, for reads, returns rvalid/rdata in t+2.
// Optional feature macro: RAM_ARB_LOCK_EN (per-bank lock, inside rr_arbiter).
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   req/lock/bank/wr/addr/wdata    : per-requester access request
//   gnt                            : combinational grant
//   rvalid/rdata                   : per-requester read return (rdata 0 when idle)
//   ram_address/ram_wr_rd/ram_wdata: registered per-bank RAM command
//   ram_rdata                      : per-bank RAM read data, one cycle after address
module ram_arbiter
    import ode_ram_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int NBANK = DEF_NBANK,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ-1:0]             lock,
    input  logic [NREQ-1:0][1:0]        bank,
    input  logic [NREQ-1:0]             wr,
    input  logic [NREQ-1:0][AW-1:0]     addr,
    input  logic [NREQ-1:0][DW-1:0]     wdata,
    output logic [NREQ-1:0]             gnt,
    output logic [NREQ-1:0]             rvalid,
    output logic [NREQ-1:0][DW-1:0]     rdata,
    output logic [NBANK-1:0][AW-1:0]    ram_address,
    output logic [NBANK-1:0]            ram_wr_rd,
    output logic [NBANK-1:0][DW-1:0]    ram_wdata,
    input  logic [NBANK-1:0][DW-1:0]    ram_rdata
);

    localparam int IW = id_w(NREQ);

    logic [NBANK-1:0][NREQ-1:0] bank_req;
    logic [NBANK-1:0][NREQ-1:0] bank_gnt;
    logic [NBANK-1:0]           bank_any;
    logic [NBANK-1:0][IW-1:0]   bank_win;

    // Read tag pipeline: [0] = RAM address cycle, [1] = RAM data cycle.
    logic [1:0][NBANK-1:0]          vld_pipe;
    logic [1:0][NBANK-1:0][IW-1:0]  tag_pipe;

    always_comb begin
        bank_req = '0;
        for (int b = 0; b < NBANK; b++)
            for (int r = 0; r < NREQ; r++)
                bank_req[b][r] = req[r] && (int'(bank[r]) == b);
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        rr_arbiter #(
            .NREQ (NREQ),
            .IW   (IW)
        ) u_arb (
            .clk     (clk),
            .rst     (rst),
            .req     (bank_req[b]),
            .lock    (lock),
            .gnt     (bank_gnt[b]),
            .gnt_any (bank_any[b]),
            .gnt_id  (bank_win[b])
        );
    end

    // A requester targets one bank, so the per-bank grants never overlap.
    always_comb begin
        gnt = '0;
        if (!rst)
            for (int b = 0; b < NBANK; b++)
                gnt = gnt | bank_gnt[b];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_address <= '0;
            ram_wdata   <= '0;
            ram_wr_rd   <= '0;
            vld_pipe    <= '0;
            tag_pipe    <= '0;
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                ram_wr_rd[b]   <= bank_any[b] && wr[bank_win[b]];
                vld_pipe[0][b] <= bank_any[b] && !wr[bank_win[b]];
                tag_pipe[0][b] <= bank_win[b];
                // Idle banks keep the last address/data to avoid needless toggling.
                if (bank_any[b]) begin
                    ram_address[b] <= addr[bank_win[b]];
                    ram_wdata[b]   <= wdata[bank_win[b]];
                end
            end
            vld_pipe[1] <= vld_pipe[0];
            tag_pipe[1] <= tag_pipe[0];
        end
    end

    // Route each bank's returning read data to the requester that issued it.
    always_comb begin
        rvalid = '0;
        rdata  = '0;
        for (int r = 0; r < NREQ; r++)
            for (int b = 0; b < NBANK; b++)
                if (vld_pipe[1][b] && tag_pipe[1][b] == IW'(r)) begin
                    rvalid[r] = 1'b1;
                    rdata[r]  = ram_rdata[b];
                end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    localparam int NREQ  = 3;
    localparam int NBANK = 4;
    localparam int AW    = 12;
    localparam int DW    = 64;
    localparam int NV    = 14;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NREQ-1:0]            req;
    logic [NREQ-1:0]            lock;
    logic [NREQ-1:0][1:0]       bank;
    logic [NREQ-1:0]            wr;
    logic [NREQ-1:0][AW-1:0]    addr;
    logic [NREQ-1:0][DW-1:0]    wdata;
    logic [NREQ-1:0]            gnt;
    logic [NREQ-1:0]            rvalid;
    logic [NREQ-1:0][DW-1:0]    rdata;
    logic [NBANK-1:0][AW-1:0]   ram_address;
    logic [NBANK-1:0]           ram_wr_rd;
    logic [NBANK-1:0][DW-1:0]   ram_wdata;
    logic [NBANK-1:0][DW-1:0]   ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.NREQ(NREQ), .NBANK(NBANK), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .lock        (lock),
        .bank        (bank),
        .wr          (wr),
        .addr        (addr),
        .wdata       (wdata),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .ram_address (ram_address),
        .ram_wr_rd   (ram_wr_rd),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    typedef struct {
        logic [2:0] req;
        logic [5:0] bank;      // {bank2, bank1, bank0}
        logic [2:0] wr;
        logic [2:0] exp_gnt;
        logic [3:0] exp_wr_rd;
        logic [2:0] exp_rv;
        logic [5:0] exp_rbank; // bank whose data each rvalid requester should see
    } vec_t;

    vec_t vecs [NV];

    function automatic logic [DW-1:0] rd_val(input int b);
        return 64'hDA7A_0000_0000_0000 + 64'(b) * 64'h1111;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        // Round-robin on bank 1, dual write, mixed read/write, read returns.
        vecs[0]  = '{3'b111, 6'b01_01_01, 3'b000, 3'b001, 4'b0000, 3'b000, 6'b00_00_00};
        vecs[1]  = '{3'b111, 6'b01_01_01, 3'b000, 3'b010, 4'b0000, 3'b000, 6'b00_00_00};
        vecs[2]  = '{3'b111, 6'b01_01_01, 3'b000, 3'b100, 4'b0000, 3'b001, 6'b00_00_01};
        vecs[3]  = '{3'b111, 6'b01_01_01, 3'b000, 3'b001, 4'b0000, 3'b010, 6'b00_01_00};
        vecs[4]  = '{3'b111, 6'b01_01_01, 3'b000, 3'b010, 4'b0000, 3'b100, 6'b01_00_00};
        vecs[5]  = '{3'b111, 6'b01_01_01, 3'b000, 3'b100, 4'b0000, 3'b001, 6'b00_00_01};
        vecs[6]  = '{3'b011, 6'b00_11_00, 3'b011, 3'b011, 4'b0000, 3'b010, 6'b00_01_00};
        vecs[7]  = '{3'b000, 6'b00_00_00, 3'b000, 3'b000, 4'b1001, 3'b100, 6'b01_00_00};
        vecs[8]  = '{3'b000, 6'b00_00_00, 3'b000, 3'b000, 4'b0000, 3'b000, 6'b00_00_00};
        vecs[9]  = '{3'b111, 6'b11_00_00, 3'b100, 3'b110, 4'b0000, 3'b000, 6'b00_00_00};
        vecs[10] = '{3'b001, 6'b11_00_00, 3'b100, 3'b001, 4'b1000, 3'b000, 6'b00_00_00};
        vecs[11] = '{3'b000, 6'b00_00_00, 3'b000, 3'b000, 4'b0000, 3'b010, 6'b00_00_00};
        vecs[12] = '{3'b000, 6'b00_00_00, 3'b000, 3'b000, 4'b0000, 3'b001, 6'b00_00_00};
        vecs[13] = '{3'b000, 6'b00_00_00, 3'b000, 3'b000, 4'b0000, 3'b000, 6'b00_00_00};

        for (int b = 0; b < NBANK; b++) ram_rdata[b] = rd_val(b);
        rst = 1'b1; req = 3'b111; lock = '0; bank = '0; wr = '0; addr = '0; wdata = '0;

        // Reset: no grants while rst, all outputs zero afterwards.
        repeat (2) begin
            @(negedge clk); #1;
            chk("gnt in reset", 64'(gnt), 64'd0);
        end
        @(negedge clk); rst = 1'b0; req = '0; #1;
        chk("reset ram_wr_rd", 64'(ram_wr_rd), 64'd0);
        chk("reset ram_address", 64'(ram_address), 64'd0);
        for (int b = 0; b < NBANK; b++) chk($sformatf("reset ram_wdata%0d", b), ram_wdata[b], 64'd0);
        chk("reset rvalid", 64'(rvalid), 64'd0);

        // Single read: req0 bank 2 addr 0x385.
        @(negedge clk); req = 3'b001; bank[0] = 2'd2; wr = '0; addr[0] = 12'h385; #1;
        chk("rd gnt", 64'(gnt), 64'b001);
        @(negedge clk); req = '0; #1;
        chk("rd ram_address2", 64'(ram_address[2]), 64'h385);
        chk("rd ram_wr_rd", 64'(ram_wr_rd), 64'd0);
        chk("rd rvalid t+1", 64'(rvalid), 64'd0);
        @(negedge clk); #1;
        chk("rd rvalid t+2", 64'(rvalid), 64'b001);
        chk("rd rdata0", rdata[0], rd_val(2));
        chk("rd rdata1 idle", rdata[1], 64'd0);
        @(negedge clk); #1;
        chk("rd rvalid t+3", 64'(rvalid), 64'd0);
        chk("rd rdata0 t+3", rdata[0], 64'd0);

        // Table-driven sequence.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            req  = vecs[i].req;
            bank = vecs[i].bank;
            wr   = vecs[i].wr;
            lock = '0;
            for (int r = 0; r < NREQ; r++) begin
                addr[r]  = AW'(12'h100 * (r + 1) + i);
                wdata[r] = 64'(i * 16 + r);
            end
            #1;
            chk($sformatf("vec%0d gnt", i), 64'(gnt), 64'(vecs[i].exp_gnt));
            chk($sformatf("vec%0d ram_wr_rd", i), 64'(ram_wr_rd), 64'(vecs[i].exp_wr_rd));
            chk($sformatf("vec%0d rvalid", i), 64'(rvalid), 64'(vecs[i].exp_rv));
            for (int r = 0; r < NREQ; r++)
                chk($sformatf("vec%0d rdata%0d", i, r), rdata[r],
                    vecs[i].exp_rv[r] ? rd_val(int'(vecs[i].exp_rbank[2*r +: 2])) : 64'd0);
        end

        // Write then idle: strobe for one cycle, address/data held.
        @(negedge clk); req = 3'b001; bank = '0; wr = 3'b001;
        addr[0] = 12'h0AB; wdata[0] = 64'h1122_3344_5566_7788; #1;
        chk("wr gnt", 64'(gnt), 64'b001);
        @(negedge clk); req = '0; addr[0] = 12'hFFF; wdata[0] = '0; #1;
        chk("wr ram_wr_rd", 64'(ram_wr_rd), 64'b0001);
        chk("wr ram_address0", 64'(ram_address[0]), 64'h0AB);
        chk("wr ram_wdata0", ram_wdata[0], 64'h1122_3344_5566_7788);
        @(negedge clk); #1;
        chk("idle ram_wr_rd", 64'(ram_wr_rd), 64'd0);
        chk("idle ram_address0 hold", 64'(ram_address[0]), 64'h0AB);
        chk("idle ram_wdata0 hold", ram_wdata[0], 64'h1122_3344_5566_7788);
        chk("idle rvalid", 64'(rvalid), 64'd0);

        // Lock: req2 locks bank 3, req0 waits on the same bank.
        @(negedge clk); req = 3'b100; lock = 3'b100; wr = '0; bank = '0; bank[2] = 2'd3; #1;
        chk("lock gnt req2", 64'(gnt), 64'b100);
        @(negedge clk); req = 3'b001; lock = '0; bank[0] = 2'd3; #1;
`ifdef RAM_ARB_LOCK_EN
        chk("lock wait 0", 64'(gnt), 64'd0);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk); #1;
            chk($sformatf("lock wait %0d", i), 64'(gnt), 64'd0);
        end
        @(negedge clk); #1;
        chk("lock timeout gnt", 64'(gnt), 64'b001);
`else
        chk("nolock gnt req0", 64'(gnt), 64'b001);
`endif
        repeat (2) begin @(negedge clk); req = '0; end

        // Lock released by the owner issuing lock=0.
        @(negedge clk); req = 3'b100; lock = 3'b100; #1;
        chk("relock gnt req2", 64'(gnt), 64'b100);
        @(negedge clk); req = 3'b101; lock = '0; #1;
`ifdef RAM_ARB_LOCK_EN
        chk("owner unlock gnt", 64'(gnt), 64'b100);
        @(negedge clk); req = 3'b001; #1;
        chk("after unlock gnt", 64'(gnt), 64'b001);
`else
        chk("rr turn gnt", 64'(gnt), 64'b001);
        @(negedge clk); req = 3'b100; #1;
        chk("rr next gnt", 64'(gnt), 64'b100);
`endif
        repeat (2) begin @(negedge clk); req = '0; end

        // Reset one cycle after a read grant.
        @(negedge clk); req = 3'b010; bank = '0; bank[1] = 2'd1; wr = '0; #1;
        chk("pre-rst gnt", 64'(gnt), 64'b010);
        @(negedge clk); rst = 1'b1; req = 3'b111; bank = 6'b01_01_01; #1;
        chk("mid rst gnt", 64'(gnt), 64'd0);
        @(negedge clk); rst = 1'b0; #1;
        chk("post rst rvalid", 64'(rvalid), 64'd0);
        for (int r = 0; r < NREQ; r++) chk($sformatf("post rst rdata%0d", r), rdata[r], 64'd0);
        chk("post rst ram_wr_rd", 64'(ram_wr_rd), 64'd0);
        chk("post rst ram_address", 64'(ram_address), 64'd0);
        for (int b = 0; b < NBANK; b++) chk($sformatf("post rst ram_wdata%0d", b), ram_wdata[b], 64'd0);
        chk("post rst gnt", 64'(gnt), 64'b001);
        @(negedge clk); req = '0; #1;
        chk("post rst rvalid t+1", 64'(rvalid), 64'd0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
